// File: rtl/cnn_pkg.sv
// +---------------------------------------------------------------------------+
// | cnn_pkg: shared constants and helpers for the CNN streaming datapath.     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  // Widest activation the shared helpers accept; narrower values are sign-extended.
  localparam int MAX_DATA_WIDTH     = 64;

  function automatic logic signed [MAX_DATA_WIDTH-1:0] signed_max(
    input logic signed [MAX_DATA_WIDTH-1:0] a,
    input logic signed [MAX_DATA_WIDTH-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_maxpool_linebuf.sv
// +---------------------------------------------------------------------------+
// | cnn_maxpool_linebuf: partial-max line buffer, 1 write / 1 async read.     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module cnn_maxpool_linebuf
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 14,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // No reset: every entry is written on an even row before the odd row reads it.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/cnn_maxpool2x2_stream.sv
// +---------------------------------------------------------------------------+
// | cnn_maxpool2x2_stream: streaming 2x2 stride-2 signed max-pool stage.      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module cnn_maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int COL_W      = $clog2(IMG_WIDTH);
  localparam int ROW_W      = $clog2(IMG_HEIGHT);
  localparam int LB_DEPTH   = IMG_WIDTH / 2;
  localparam int LB_ADDR_W  = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  generate
    if ((IMG_WIDTH < 2) || (IMG_WIDTH % 2 != 0) ||
        (IMG_HEIGHT < 2) || (IMG_HEIGHT % 2 != 0) ||
        (DATA_WIDTH < 1) || (DATA_WIDTH > MAX_DATA_WIDTH)) begin : g_param_check
      $fatal(1, "cnn_maxpool2x2_stream: illegal parameters W=%0d H=%0d DW=%0d",
             IMG_WIDTH, IMG_HEIGHT, DATA_WIDTH);
    end
  endgenerate

  function automatic logic [DATA_WIDTH-1:0] pmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic signed [MAX_DATA_WIDTH-1:0] ea;
    logic signed [MAX_DATA_WIDTH-1:0] eb;
    ea = MAX_DATA_WIDTH'($signed(a));
    eb = MAX_DATA_WIDTH'($signed(b));
    return (signed_max(ea, eb) == ea) ? a : b;
  endfunction

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] lb_rd_data;
  logic [LB_ADDR_W-1:0]  lb_addr;
  logic                  accept;
  logic                  lb_wr_en;
  logic                  new_result;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign lb_addr    = LB_ADDR_W'(col >> 1);
  assign lb_wr_en   = accept && !row[0] && col[0];
  assign new_result = accept && row[0] && col[0];

  cnn_maxpool_linebuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (LB_DEPTH),
    .ADDR_WIDTH (LB_ADDR_W)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (pmax(hold, in_data)),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  // Raster position and the horizontal/vertical partial max of the open window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      hold <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (!col[0]) begin
        hold <= row[0] ? pmax(lb_rd_data, in_data) : in_data;
      end
    end
  end

  // A fresh result takes priority over draining, so a same-cycle handoff keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (new_result) begin
      out_valid <= 1'b1;
      out_data  <= pmax(hold, in_data);
      out_last  <= (row == ROW_LAST) && (col == COL_LAST);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cnn_maxpool2x2_stream.sv
// +---------------------------------------------------------------------------+
// | tb_cnn_maxpool2x2_stream: randomized self-checking bench with window model|
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_cnn_maxpool2x2_stream;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] s_in_data;
  logic          s_in_valid;
  logic          s_in_ready;
  logic [DW-1:0] s_out_data;
  logic          s_out_valid;
  logic          s_out_ready;
  logic          s_out_last;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cnn_maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  cnn_maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(6), .IMG_HEIGHT(2)) u_dut_wide (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_last(s_out_last)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag,
               $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Reference: gather whole accepted frames, then pool them with plain array arithmetic.
  int   frame[$];
  int   exp_q[$];
  bit   exp_last_q[$];
  int   got_q[$];
  bit   got_last_q[$];
  int   s_got_q[$];
  bit   s_got_last_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      frame.delete();
    end else begin
      if (in_valid && in_ready) begin
        frame.push_back(int'(in_data));
        if (frame.size() == W * H) begin
          for (int r = 0; r < H; r += 2) begin
            for (int c = 0; c < W; c += 2) begin
              int m;
              m = frame[r*W + c];
              if (frame[r*W + c + 1]     > m) m = frame[r*W + c + 1];
              if (frame[(r+1)*W + c]     > m) m = frame[(r+1)*W + c];
              if (frame[(r+1)*W + c + 1] > m) m = frame[(r+1)*W + c + 1];
              exp_q.push_back(m);
              exp_last_q.push_back((r == H - 2) && (c == W - 2));
            end
          end
          frame.delete();
        end
      end
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_data));
        got_last_q.push_back(out_last);
      end
      if (s_out_valid && s_out_ready) begin
        s_got_q.push_back(int'(s_out_data));
        s_got_last_q.push_back(s_out_last);
      end
    end
  end

  task automatic drain();
    int guard = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  // Feeds pixels; optional random valid/ready, ready-always check, and a 5-cycle stall on the first output.
  task automatic send(input int px[$], input bit rnd_valid, input bit rnd_ready,
                      input bit chk_ready, input bit stall5);
    int  i = 0;
    int  guard = 0;
    int  stall = 0;
    bit  stalled = 0;
    while (i < px.size() && guard < 4000) begin
      @(posedge clk); #1;
      in_valid  = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = px[i];
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall5 && !stalled && out_valid) begin
        stall   = 5;
        stalled = 1;
      end
      if (stall > 0) out_ready = 1'b0;
      @(negedge clk);
      if (stall > 0) begin
        check("bp_out_data", out_data, 5);
        check("bp_in_ready", {31'b0, in_ready}, 0);
        stall--;
      end
      if (chk_ready) check("ramp_in_ready", {31'b0, in_ready}, 1);
      if (in_valid && in_ready) i++;
      guard++;
    end
    if (guard >= 4000) check("send_timeout", 1, 0);
    drain();
  endtask

  task automatic compare(input string tag, input int dir[$]);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    if (dir.size() != 0) check({tag, "_dir_count"}, got_q.size(), dir.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_data"}, got_q[i], exp_q[i]);
      check({tag, "_last"}, {31'b0, got_last_q[i]}, {31'b0, exp_last_q[i]});
      if (i < dir.size()) check({tag, "_dir"}, got_q[i], dir[i]);
    end
    got_q.delete(); got_last_q.delete(); exp_q.delete(); exp_last_q.delete();
  endtask

  int ramp[$];
  int neg[$];
  int part[$];
  int rnd[$];
  int ramp_exp[$];
  int neg_exp[$];
  int none[$];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp.push_back(i);
      neg.push_back(-(i + 1));
    end
    for (int i = 0; i < 9; i++) part.push_back(i);
    for (int i = 0; i < 3 * W * H; i++) rnd.push_back(int'($urandom));
    ramp_exp.push_back(5);  ramp_exp.push_back(7);  ramp_exp.push_back(13); ramp_exp.push_back(15);
    neg_exp.push_back(-1);  neg_exp.push_back(-3);  neg_exp.push_back(-9);  neg_exp.push_back(-11);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_last",  {31'b0, out_last}, 0);
    check("rst_in_ready",  {31'b0, in_ready}, 1);

    send(ramp, 0, 0, 1, 0);
    compare("ramp", ramp_exp);

    send(neg, 0, 0, 0, 0);
    compare("signed", neg_exp);

    send(ramp, 0, 0, 0, 1);
    compare("backpressure", ramp_exp);

    send(rnd, 1, 1, 0, 0);
    check("bursty_outputs", got_q.size(), 12);
    compare("bursty", none);

    send(part, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    got_q.delete(); got_last_q.delete(); exp_q.delete(); exp_last_q.delete();
    send(ramp, 0, 0, 0, 0);
    compare("reset_mid", ramp_exp);

    for (int i = 0; i < 12; i++) begin
      int guard = 0;
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      s_in_data  = i;
      @(negedge clk);
      while (!s_in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("wide_timeout", 1, 0);
    end
    @(posedge clk); #1 s_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wide_count", s_got_q.size(), 3);
    if (s_got_q.size() == 3) begin
      check("wide_data0", s_got_q[0], 7);
      check("wide_data1", s_got_q[1], 9);
      check("wide_data2", s_got_q[2], 11);
      check("wide_last0", {31'b0, s_got_last_q[0]}, 0);
      check("wide_last1", {31'b0, s_got_last_q[1]}, 0);
      check("wide_last2", {31'b0, s_got_last_q[2]}, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
